// File: rtl/usr_pkg.sv
// Shared definitions for the serial deserializer: FSM state encoding and
// default sizing constants.
package usr_pkg;

    localparam int USR_DEFAULT_WIDTH = 4;
    localparam int USR_OVERRUN_LIMIT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Counts accepted serial bits within the current word and flags the last
// bit position so the deserializer knows when a word completes.
module shift_bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(WIDTH - 1));

    // Wraps to zero on the last bit so the count never reaches WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Collects serial bits into WIDTH-bit words with a ready/valid output stage,
// flush support and a sticky overrun flag for long input stalls.
module serial_deserializer
    import usr_pkg::*;
#(
    parameter  int WIDTH     = USR_DEFAULT_WIDTH,
    parameter  int MSB_FIRST = 1,
    localparam int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    localparam int SCW = $clog2(USR_OVERRUN_LIMIT);

    usr_state_e       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             tc;
    logic             last_bit;
    logic             accept;
    logic             complete;
    logic             stall;
    logic [SCW-1:0]   stall_count;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .clr   (flush),
        .count (bit_count),
        .tc    (tc)
    );

    // The final bit of a word may only enter if the output register can take it.
    assign last_bit = (state == SHIFT) && tc;
    assign s_ready  = !(last_bit && m_valid && !m_ready);
    assign accept   = s_valid && s_ready && !flush;
    assign complete = accept && last_bit;
    assign stall    = s_valid && !s_ready;

    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[WIDTH-2:0], s_bit};
        end else begin
            shift_next = {s_bit, shift_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
        end else begin
            if (complete) begin
                m_data  <= shift_next;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            // Flush only touches the partial word; the output stage is left alone.
            if (flush) begin
                shift_reg <= '0;
                state     <= IDLE;
            end else if (accept) begin
                if (complete) begin
                    shift_reg <= '0;
                    state     <= IDLE;
                end else begin
                    shift_reg <= shift_next;
                    state     <= SHIFT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            overrun     <= 1'b0;
        end else if (stall) begin
            if (stall_count == SCW'(USR_OVERRUN_LIMIT - 1)) begin
                overrun <= 1'b1;
            end else begin
                stall_count <= stall_count + SCW'(1);
            end
        end else begin
            stall_count <= '0;
        end
    end

endmodule
